// File: rtl/bubble_buffer_loader_if.sv
// rtl/bubble_buffer_loader_if.sv - byte stream and output-buffer write bus for bubble_buffer_loader
interface bubble_buffer_loader_if #(
    parameter int ADDR_W = 15
);
    logic [7:0]        BYTE_DATA;
    logic              BYTE_VALID;
    logic              BYTE_READY;
    logic              nOUTBUFWRCLKEN;
    logic [ADDR_W-1:0] OUTBUFWRADDR;
    logic              OUTBUFWRDATA;

    modport master (
        input  BYTE_DATA,
        input  BYTE_VALID,
        output BYTE_READY,
        output nOUTBUFWRCLKEN,
        output OUTBUFWRADDR,
        output OUTBUFWRDATA
    );

    modport slave (
        output BYTE_DATA,
        output BYTE_VALID,
        input  BYTE_READY,
        input  nOUTBUFWRCLKEN,
        input  OUTBUFWRADDR,
        input  OUTBUFWRDATA
    );
endinterface

// File: rtl/bubble_buffer_loader.sv
// rtl/bubble_buffer_loader.sv - MSB-first byte-to-bit loader for the bubble output buffer (optional BUFLOADER_CHECKSUM_EN)
module bubble_buffer_loader #(
    parameter int ADDR_W = 15,
    parameter int LEN_W  = 16
) (
    input  logic                   MCLK,
    input  logic                   nRESET,
    input  logic                   START,
    input  logic [ADDR_W-1:0]      START_ADDR,
    input  logic [LEN_W-1:0]       BITLEN,
    input  logic                   ABORT,
    bubble_buffer_loader_if.master bus,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [15:0]            CHECKSUM
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SHIFT  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  remain_q;
    logic [7:0]        shreg_q;
    logic [2:0]        bitidx_q;

    logic              wr_n_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              wr_data_q;
    logic              done_q;

    logic              start_acc;
    logic              byte_acc;
    logic              shift_en;

    // ABORT wins over a same-cycle byte, so the loader never sees a completed handshake that is dropped
    assign bus.BYTE_READY     = (state_q == FETCH) && !ABORT;
    assign bus.nOUTBUFWRCLKEN = wr_n_q;
    assign bus.OUTBUFWRADDR   = wr_addr_q;
    assign bus.OUTBUFWRDATA   = wr_data_q;
    assign BUSY               = (state_q != IDLE);
    assign DONE               = done_q;

    // State register
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle datapath strobes
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        byte_acc  = 1'b0;
        shift_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    start_acc = 1'b1;
                    state_d   = (BITLEN == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                if (ABORT) begin
                    state_d = IDLE;
                end else if (bus.BYTE_VALID) begin
                    byte_acc = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (ABORT) begin
                    state_d = IDLE;
                end else begin
                    shift_en = 1'b1;
                    if (remain_q == LEN_W'(1)) begin
                        state_d = FINISH;
                    end else if (bitidx_q == 3'd0) begin
                        state_d = FETCH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address/length/shift datapath; write bus is registered one cycle behind the SHIFT state
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            addr_q    <= '0;
            remain_q  <= '0;
            shreg_q   <= '0;
            bitidx_q  <= '0;
            wr_n_q    <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (start_acc) begin
                addr_q   <= START_ADDR;
                remain_q <= BITLEN;
            end
            if (byte_acc) begin
                shreg_q  <= bus.BYTE_DATA;
                bitidx_q <= 3'd7;
            end
            if (shift_en) begin
                shreg_q   <= {shreg_q[6:0], 1'b0};
                addr_q    <= addr_q + ADDR_W'(1);
                remain_q  <= remain_q - LEN_W'(1);
                bitidx_q  <= bitidx_q - 3'd1;
                wr_addr_q <= addr_q;
                wr_data_q <= shreg_q[7];
            end
            wr_n_q <= !shift_en;
            done_q <= (state_q == FINISH) && !ABORT;
        end
    end

`ifdef BUFLOADER_CHECKSUM_EN
    logic [15:0] csum_q;

    // Running byte sum of the current transfer, held until the next accepted START
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            csum_q <= '0;
        end else if (start_acc) begin
            csum_q <= '0;
        end else if (byte_acc) begin
            csum_q <= csum_q + {8'd0, bus.BYTE_DATA};
        end
    end

    assign CHECKSUM = csum_q;
`else
    assign CHECKSUM = 16'd0;
`endif

endmodule

// File: tb/tb_bubble_buffer_loader.sv
// tb/tb_bubble_buffer_loader.sv - randomized self-checking bench for bubble_buffer_loader
module tb_bubble_buffer_loader;
    localparam int ADDR_W = 15;
    localparam int LEN_W  = 16;

    logic              MCLK = 1'b0;
    logic              nRESET = 1'b0;
    logic              START = 1'b0;
    logic [ADDR_W-1:0] START_ADDR = '0;
    logic [LEN_W-1:0]  BITLEN = '0;
    logic              ABORT = 1'b0;
    logic              BUSY;
    logic              DONE;
    logic [15:0]       CHECKSUM;

    bubble_buffer_loader_if #(.ADDR_W(ADDR_W)) bus ();

    bubble_buffer_loader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .MCLK       (MCLK),
        .nRESET     (nRESET),
        .START      (START),
        .START_ADDR (START_ADDR),
        .BITLEN     (BITLEN),
        .ABORT      (ABORT),
        .bus        (bus),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .CHECKSUM   (CHECKSUM)
    );

    always #5 MCLK = ~MCLK;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              data;
        int                cyc;
    } wr_t;

    wr_t         wr_log[$];
    int          done_cnt = 0;
    int          cyc_cnt  = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  byte_q[$];
    logic [15:0] exp_sum  = '0;
    int          stall1   = 0;

    always @(negedge MCLK) begin
        wr_t w;
        cyc_cnt = cyc_cnt + 1;
        if (nRESET && !bus.nOUTBUFWRCLKEN) begin
            w.addr = bus.OUTBUFWRADDR;
            w.data = bus.OUTBUFWRDATA;
            w.cyc  = cyc_cnt;
            wr_log.push_back(w);
        end
        if (nRESET && DONE) done_cnt = done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_csum();
`ifdef BUFLOADER_CHECKSUM_EN
        return exp_sum;
`else
        return 16'd0;
`endif
    endfunction

    task automatic sample();
        @(negedge MCLK);
        #1;
    endtask

    task automatic feed_byte(input logic [7:0] d, input int stall);
        int t = 0;
        bus.BYTE_VALID = 1'b0;
        while (t < 300) begin
            @(negedge MCLK);
            if (bus.BYTE_READY) break;
            t++;
        end
        if (t >= 300) check_eq("feed_timeout", 0, 1);
        repeat (stall) @(negedge MCLK);
        bus.BYTE_DATA  = d;
        bus.BYTE_VALID = 1'b1;
        @(posedge MCLK);
        #1;
        bus.BYTE_VALID = 1'b0;
        exp_sum = exp_sum + {8'd0, d};
    endtask

    task automatic wait_done(input string tag, input int base_d);
        int t = 0;
        while (done_cnt == base_d && t < 400) begin
            sample();
            t++;
        end
        if (t >= 400) check_eq({tag, "_done_timeout"}, 0, 1);
    endtask

    task automatic verify_writes(input string tag, input int base, input logic [ADDR_W-1:0] sa, input int nbits);
        int got_n;
        got_n = wr_log.size() - base;
        check_eq({tag, "_nwr"}, got_n, nbits);
        for (int i = 0; i < nbits && i < got_n; i++) begin
            logic [7:0] bv;
            int         ea;
            bv = byte_q[i / 8];
            ea = (int'(sa) + i) % (1 << ADDR_W);
            check_eq($sformatf("%s_addr%0d", tag, i), 32'(wr_log[base + i].addr), ea);
            check_eq($sformatf("%s_bit%0d", tag, i), 32'(wr_log[base + i].data), 32'(bv[7 - (i % 8)]));
        end
    endtask

    task automatic run_xfer(input string tag, input logic [ADDR_W-1:0] sa, input logic [LEN_W-1:0] bl,
                            input int stall_lo, input int stall_hi, input bit spurious);
        int base_w;
        int base_d;
        int nb;
        int st;
        base_w = wr_log.size();
        base_d = done_cnt;
        nb     = (int'(bl) + 7) / 8;
        stall1 = 0;
        @(posedge MCLK);
        #1;
        START = 1'b1; START_ADDR = sa; BITLEN = bl;
        exp_sum = '0;
        @(posedge MCLK);
        #1;
        START = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if (spurious && b == 1) begin
                START = 1'b1; START_ADDR = 15'd123; BITLEN = 16'd1;
                @(posedge MCLK);
                #1;
                START = 1'b0;
            end
            st = int'($urandom_range(stall_hi, stall_lo));
            if (b == 1) stall1 = st;
            feed_byte(byte_q[b], st);
        end
        wait_done(tag, base_d);
        check_eq({tag, "_busy_end"}, BUSY, 0);
        check_eq({tag, "_ready_end"}, bus.BYTE_READY, 0);
        verify_writes(tag, base_w, sa, int'(bl));
        if (bl > 8 && wr_log.size() >= base_w + 9)
            check_eq({tag, "_gap"}, wr_log[base_w + 8].cyc - wr_log[base_w + 7].cyc, 2 + stall1);
        check_eq({tag, "_csum"}, CHECKSUM, exp_csum());
        repeat (2) sample();
        check_eq({tag, "_done_once"}, done_cnt, base_d + 1);
        check_eq({tag, "_strobe_idle"}, bus.nOUTBUFWRCLKEN, 1);
        check_eq({tag, "_ready_idle"}, bus.BYTE_READY, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_w;
        int base_d;
        int t;
        bus.BYTE_DATA  = 8'd0;
        bus.BYTE_VALID = 1'b0;

        #12;
        check_eq("rst_strobe", bus.nOUTBUFWRCLKEN, 1);
        check_eq("rst_addr", bus.OUTBUFWRADDR, 0);
        check_eq("rst_data", bus.OUTBUFWRDATA, 0);
        check_eq("rst_ready", bus.BYTE_READY, 0);
        check_eq("rst_busy", BUSY, 0);
        check_eq("rst_done", DONE, 0);
        check_eq("rst_csum", CHECKSUM, 0);
        @(posedge MCLK);
        #1;
        nRESET = 1'b1;

        byte_q = {};
        byte_q.push_back(8'hA5); byte_q.push_back(8'h3C);
        run_xfer("basic", 15'd0, 16'd16, 0, 0, 1'b0);

        byte_q = {};
        byte_q.push_back(8'hE0);
        run_xfer("partial", 15'd14342, 16'd3, 0, 0, 1'b0);

        base_w = wr_log.size();
        base_d = done_cnt;
        @(posedge MCLK);
        #1;
        START = 1'b1; START_ADDR = 15'd5; BITLEN = 16'd0;
        @(posedge MCLK);
        #1;
        START = 1'b0;
        sample();
        check_eq("zl_done_early", DONE, 0);
        check_eq("zl_busy", BUSY, 1);
        sample();
        check_eq("zl_done", DONE, 1);
        repeat (3) sample();
        check_eq("zl_done_once", done_cnt, base_d + 1);
        check_eq("zl_nwr", wr_log.size() - base_w, 0);
        exp_sum = '0;
        check_eq("zl_csum", CHECKSUM, exp_csum());

        byte_q = {};
        byte_q.push_back(8'hF0);
        run_xfer("wrap", 15'd32766, 16'd4, 0, 0, 1'b0);

        byte_q = {};
        byte_q.push_back(8'h96); byte_q.push_back(8'h69);
        run_xfer("stall", 15'd300, 16'd16, 5, 5, 1'b1);

        byte_q = {};
        byte_q.push_back(8'hFF); byte_q.push_back(8'h02);
        run_xfer("csum", 15'd500, 16'd16, 0, 1, 1'b0);
`ifdef BUFLOADER_CHECKSUM_EN
        check_eq("csum_value", CHECKSUM, 16'h0101);
`else
        check_eq("csum_value", CHECKSUM, 16'h0000);
`endif

        byte_q = {};
        byte_q.push_back(8'hC3); byte_q.push_back(8'h5A);
        base_w = wr_log.size();
        base_d = done_cnt;
        @(posedge MCLK);
        #1;
        START = 1'b1; START_ADDR = 15'd100; BITLEN = 16'd16;
        exp_sum = '0;
        @(posedge MCLK);
        #1;
        START = 1'b0;
        feed_byte(8'hC3, 0);
        t = 0;
        while (wr_log.size() - base_w < 5 && t < 100) begin
            sample();
            t++;
        end
        if (t >= 100) check_eq("abort_wait_timeout", 0, 1);
        ABORT = 1'b1;
        @(posedge MCLK);
        #1;
        ABORT = 1'b0;
        sample();
        check_eq("abort_busy", BUSY, 0);
        check_eq("abort_strobe", bus.nOUTBUFWRCLKEN, 1);
        repeat (10) sample();
        verify_writes("abort", base_w, 15'd100, 5);
        check_eq("abort_no_done", done_cnt, base_d);
        check_eq("abort_csum", CHECKSUM, exp_csum());

        byte_q = {};
        byte_q.push_back(8'h81);
        base_w = wr_log.size();
        @(posedge MCLK);
        #1;
        START = 1'b1; START_ADDR = 15'd200; BITLEN = 16'd16;
        @(posedge MCLK);
        #1;
        START = 1'b0;
        feed_byte(8'h81, 0);
        t = 0;
        while (wr_log.size() - base_w < 3 && t < 100) begin
            sample();
            t++;
        end
        if (t >= 100) check_eq("rst_wait_timeout", 0, 1);
        check_eq("mid_strobe_low", bus.nOUTBUFWRCLKEN, 0);
        nRESET = 1'b0;
        #1;
        check_eq("arst_strobe", bus.nOUTBUFWRCLKEN, 1);
        check_eq("arst_addr", bus.OUTBUFWRADDR, 0);
        check_eq("arst_data", bus.OUTBUFWRDATA, 0);
        check_eq("arst_busy", BUSY, 0);
        check_eq("arst_ready", bus.BYTE_READY, 0);
        check_eq("arst_done", DONE, 0);
        check_eq("arst_csum", CHECKSUM, 0);
        @(posedge MCLK);
        #1;
        nRESET = 1'b1;

        for (int n = 0; n < 25; n++) begin
            logic [ADDR_W-1:0] sa;
            logic [LEN_W-1:0]  bl;
            sa = ADDR_W'($urandom);
            if (n % 4 == 0) sa = 15'd32760 + ADDR_W'($urandom_range(7, 0));
            bl = LEN_W'($urandom_range(40, 0));
            byte_q = {};
            for (int b = 0; b < 6; b++) byte_q.push_back(8'($urandom));
            run_xfer($sformatf("rnd%0d", n), sa, bl, 0, 3, 1'(n % 3 == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
